// File: rtl/rv_mem_pkg.sv
// Shared definitions for the MEM-stage data-bus interface: funct3 access codes,
// FSM state encoding and the lane/byte-enable helpers used by mem_access.
package rv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // funct3[1:0] encodes the access size for loads and stores alike.
  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] lane);
    unique case (f3[1:0])
      2'b00:   byte_en = 4'b0001 << lane;
      2'b01:   byte_en = 4'b0011 << {lane[1], 1'b0};
      default: byte_en = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] wdata);
    unique case (f3[1:0])
      2'b00:   store_lanes = {4{wdata[7:0]}};
      2'b01:   store_lanes = {2{wdata[15:0]}};
      default: store_lanes = wdata;
    endcase
  endfunction

  function automatic logic access_fault(input logic [2:0] f3, input logic [1:0] lane,
                                        input logic is_store);
    logic bad_f3;
    logic misaligned;
    bad_f3     = !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    misaligned = ((f3[1:0] == 2'b01) && lane[0]) || ((f3[1:0] == 2'b10) && (lane != 2'b00));
    access_fault = bad_f3 || misaligned || (is_store && f3[2]);
  endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// Picks the addressed byte/halfword out of a bus word and sign- or
// zero-extends it according to funct3.
module load_align
  import rv_mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    lane_b = rdata_i[7:0];
    unique case (addr_i)
      2'd0: lane_b = rdata_i[7:0];
      2'd1: lane_b = rdata_i[15:8];
      2'd2: lane_b = rdata_i[23:16];
      2'd3: lane_b = rdata_i[31:24];
    endcase
    lane_h = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    data_o = rdata_i;
    unique case (funct3_i)
      F3_B:    data_o = {{24{lane_b[7]}}, lane_b};
      F3_H:    data_o = {{16{lane_h[15]}}, lane_h};
      F3_BU:   data_o = {24'h0, lane_b};
      F3_HU:   data_o = {16'h0, lane_h};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM stage: runs one load/store per instruction over a req/ready bus,
// stalling the PC until the access completes, faults or times out.
module mem_access
  import rv_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemWE,
  input  logic        MemRE,
  input  logic [2:0]  funct3,
  input  logic [31:0] Addr,
  input  logic [31:0] WData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        Fault,
  output logic        BusErr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam int unsigned      CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e      state_q;
  logic        req_q, we_q, bus_err_q;
  logic [31:0] addr_q, wdata_q, read_data_q;
  logic [3:0]  be_q;
  logic [1:0]  lane_q;
  logic [2:0]  f3_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0] load_val;
  logic        acc, fault, start;

  assign acc   = MemWE | MemRE;
  assign fault = acc & access_fault(funct3, Addr[1:0], MemWE);
  assign start = acc & ~fault;

  // Gated by rst so the PC is released the moment reset asserts mid-access.
  assign Stall = rst & (((state_q == S_IDLE) & start) | (state_q == S_BUSY));
  assign Fault = fault;

  load_align u_align (
    .rdata_i (mem_rdata),
    .addr_i  (lane_q),
    .funct3_i(f3_q),
    .data_o  (load_val)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      bus_err_q   <= 1'b0;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      read_data_q <= '0;
      lane_q      <= '0;
      f3_q        <= '0;
      cnt_q       <= '0;
    end else begin
      bus_err_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_BUSY;
            req_q   <= 1'b1;
            we_q    <= MemWE;
            addr_q  <= {Addr[31:2], 2'b00};
            be_q    <= byte_en(funct3, Addr[1:0]);
            wdata_q <= store_lanes(funct3, WData);
            lane_q  <= Addr[1:0];
            f3_q    <= funct3;
            cnt_q   <= '0;
          end
        end
        S_BUSY: begin
          if (mem_ready) begin
            state_q <= S_DONE;
            req_q   <= 1'b0;
            if (!we_q) read_data_q <= load_val;
          end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
            state_q     <= S_DONE;
            req_q       <= 1'b0;
            bus_err_q   <= 1'b1;
            read_data_q <= '0;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ReadData  = read_data_q;
  assign BusErr    = bus_err_q;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed cases plus randomized accesses
// against a word-array memory and an arithmetic load/store reference model.
module tb_mem_access;
  import rv_mem_pkg::*;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        MemWE = 1'b0, MemRE = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] Addr = '0, WData = '0, mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic [31:0] ReadData, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        Stall, Fault, BusErr, mem_req, mem_we;

  int          n_vec = 0;
  int          n_miss = 0;
  logic [31:0] mem [int];
  logic [31:0] rd_model = '0;

  mem_access #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst_n), .MemWE(MemWE), .MemRE(MemRE), .funct3(funct3),
    .Addr(Addr), .WData(WData), .ReadData(ReadData), .Stall(Stall), .Fault(Fault),
    .BusErr(BusErr), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    int idx;
    idx = int'(a >> 2);
    return mem.exists(idx) ? mem[idx] : 32'h0;
  endfunction

  function automatic bit model_fault(input logic [2:0] f3, input logic [31:0] a, input bit st);
    int size;
    if (!(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5)) return 1'b1;
    if (st && f3 >= 3'd4) return 1'b1;
    size = 1 << int'(f3[1:0]);
    return (int'(a[1:0]) % size) != 0;
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] word, input logic [31:0] a,
                                           input logic [2:0] f3);
    int          off;
    logic [31:0] b, h;
    off = int'(a[1:0]);
    b = (word >> (8 * off)) & 32'hFF;
    h = (word >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'd128)   ? b - 32'd256   : b;
      3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'd2:    return word;
      3'd4:    return b;
      3'd5:    return h;
      default: return 32'h0;
    endcase
  endfunction

  // lat = BUSY cycle (1-based) on which mem_ready pulses; 0 means never.
  task automatic do_access(input logic we, input logic re, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd, input int lat);
    bit          st, flt, done_ok, to;
    int          off, size, stalls;
    logic [3:0]  be_e;
    logic [31:0] wd_e, word;
    st   = we;
    off  = int'(addr[1:0]);
    size = int'(f3[1:0]);
    flt  = model_fault(f3, addr, st);
    be_e = (size == 0) ? 4'(1 << off) : (size == 1) ? 4'(3 << (off & 2)) : 4'hF;
    wd_e = (size == 0) ? (wd & 32'hFF) * 32'h0101_0101 :
           (size == 1) ? (wd & 32'hFFFF) * 32'h0001_0001 : wd;

    MemWE = we; MemRE = re; funct3 = f3; Addr = addr; WData = wd;
    #1;
    check("fault", Fault, flt);
    if (flt) begin
      check("fault_stall", Stall, 0);
      repeat (2) begin
        tick();
        check("fault_noreq", mem_req, 0);
        check("fault_rdata", ReadData, rd_model);
      end
      MemWE = 0; MemRE = 0;
      #1;
      return;
    end

    check("idle_stall", Stall, 1);
    stalls = 1;
    word = mem_rd(addr);
    tick();
    done_ok = 0; to = 0;
    for (int k = 1; k <= int'(TO) + 4; k++) begin
      check("busy_stall", Stall, 1);
      stalls++;
      check("busy_req", mem_req, 1);
      check("mem_we", mem_we, st);
      check("mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
      check("mem_be", mem_be, be_e);
      check("mem_wdata", mem_wdata, wd_e);
      if (k == lat) begin
        mem_ready = 1;
        mem_rdata = st ? $urandom : word;
      end
      tick();
      mem_ready = 0;
      mem_rdata = $urandom;
      if (k == lat) begin done_ok = 1; break; end
      if (lat == 0 && k == int'(TO)) begin done_ok = 1; to = 1; break; end
    end
    if (!done_ok) check("busy_bound_stall", Stall, 0);

    if (to) rd_model = 32'h0;
    else if (st) begin
      for (int b = 0; b < 4; b++) if (be_e[b]) word[8*b +: 8] = wd_e[8*b +: 8];
      mem[int'(addr >> 2)] = word;
    end else rd_model = exp_load(word, addr, f3);

    check("done_stall", Stall, 0);
    check("done_req", mem_req, 0);
    check("buserr", BusErr, to);
    check("readdata", ReadData, rd_model);
    check("stall_cycles", stalls, to ? 32'(TO + 1) : 32'(lat + 1));
    tick();
    MemWE = 0; MemRE = 0;
    #1;
    check("buserr_pulse", BusErr, 0);
    check("idle_after", Stall, 0);
  endtask

  initial begin
    logic [2:0]  rf3;
    logic [31:0] raddr;
    int          op;

    #12;
    check("rst_req", mem_req, 0);
    check("rst_we", mem_we, 0);
    check("rst_buserr", BusErr, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_be", mem_be, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_rdata", ReadData, 0);
    check("rst_stall", Stall, 0);
    #5 rst_n = 1;
    tick();

    mem[4] = 32'hDEAD_BEEF;
    do_access(0, 1, F3_W, 32'h10, 32'h0, 2);
    mem[4] = 32'h80FF_FF01;
    do_access(0, 1, F3_B, 32'h13, 32'h0, 1);
    do_access(0, 1, F3_BU, 32'h13, 32'h0, 3);
    do_access(1, 0, F3_H, 32'h22, 32'h1234_ABCD, 1);
    do_access(0, 1, F3_HU, 32'h22, 32'h0, 1);
    do_access(0, 1, F3_W, 32'h06, 32'h0, 1);
    do_access(1, 0, 3'b100, 32'h40, 32'h55, 1);
    do_access(1, 1, F3_W, 32'h30, 32'hCAFE_F00D, 2);
    do_access(0, 1, F3_H, 32'h32, 32'h0, 1);
    do_access(0, 1, F3_W, 32'h10, 32'h0, 0);

    // mem_ready in IDLE must be ignored.
    mem_ready = 1; mem_rdata = 32'h5555_AAAA;
    tick();
    mem_ready = 0;
    check("stray_ready_rdata", ReadData, rd_model);
    check("stray_ready_req", mem_req, 0);

    // Asynchronous reset while BUSY.
    MemRE = 1; funct3 = F3_W; Addr = 32'h10;
    tick();
    check("pre_rst_req", mem_req, 1);
    #2 rst_n = 0;
    #1;
    rd_model = 32'h0;
    check("rst_busy_req", mem_req, 0);
    check("rst_busy_stall", Stall, 0);
    check("rst_busy_rdata", ReadData, rd_model);
    MemRE = 0;
    #1 rst_n = 1;
    tick();
    do_access(0, 1, F3_W, 32'h10, 32'h0, 1);

    for (int i = 0; i < 40; i++) begin
      rf3   = 3'($urandom_range(0, 7));
      raddr = {24'h0, 4'($urandom_range(0, 15)), 2'b00, 2'b00};
      if ($urandom_range(0, 1) == 1) raddr[1:0] = 2'($urandom_range(0, 3));
      op = $urandom_range(0, 2);
      do_access(op != 0, op != 1, rf3, raddr, $urandom, $urandom_range(1, 4));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
